// File: rtl/lock_sequencer_pkg.sv
// Shared state codes, key codes and small helpers for the six-digit lock.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package lock_sequencer_pkg;

    localparam int DIGITS_DEF = 6;

    // Encodings are visible on the state output, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ST_LOCKED = 3'd0,
        ST_CHECK  = 3'd1,
        ST_OPEN   = 3'd2,
        ST_SET    = 3'd3,
        ST_ALARM  = 3'd4
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_SET   = 4'hC;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that flags the last cycle of a timed interval.
// Latency: load takes effect next cycle; expired is combinational from the count.
// Backpressure: none; en simply freezes the count.
//
// Ports:
//   clk, rst_n  clock, async active-low reset (count cleared)
//   load        load strobe, has priority over en
//   load_val    value loaded on load
//   en          count down by one per cycle while non-zero
//   expired     high for the single cycle in which the interval ends
module lock_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // Firing at a count of one makes a loaded value of N give exactly N
    // enabled cycles; a count of zero is included so an enabled idle timer
    // can never hold the FSM forever.
    assign expired = en && !load && (count <= WIDTH'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock controller: digit entry, password compare, error lockout, door hold-open.
// Latency: ENTER in cycle N -> CHECK in N+1 -> unlocked/alarm/err_cnt valid in N+2.
// Backpressure: none; key strobes that are not meaningful in the current state are dropped.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   key_valid   one-cycle strobe qualifying key_code
//   key_code    0-9 digit, A ENTER, B CLEAR, C SET, others ignored
//   unlocked    high in OPEN and SET
//   alarm       high in ALARM
//   err_cnt     consecutive failed attempts, saturating at MAX_ERR
//   digit_cnt   digits held in entry_buf
//   entry_buf   entered digits, newest in [3:0]
//   state       current FSM state code
module lock_sequencer
    import lock_sequencer_pkg::*;
#(
    parameter int                  DIGITS      = DIGITS_DEF,
    parameter int                  MAX_ERR     = 3,
    parameter int                  OPEN_CYC    = 500,
    parameter int                  LOCKOUT_CYC = 1000,
    parameter logic [4*DIGITS-1:0] DEFAULT_PW  = 24'h123456
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic                unlocked,
    output logic                alarm,
    output logic [1:0]          err_cnt,
    output logic [2:0]          digit_cnt,
    output logic [4*DIGITS-1:0] entry_buf,
    output logic [2:0]          state
);

    localparam int             BW        = 4 * DIGITS;
    localparam int             TW        = $clog2(max2(OPEN_CYC, LOCKOUT_CYC) + 1);
    localparam logic [TW-1:0]  OPEN_VAL  = TW'(OPEN_CYC);
    localparam logic [TW-1:0]  LOCK_VAL  = TW'(LOCKOUT_CYC);
    localparam logic [2:0]     DIG_FULL  = 3'(DIGITS);
    localparam logic [1:0]     ERR_SAT   = 2'(MAX_ERR);

    state_t          cur_state, nxt_state;
    logic [BW-1:0]   password,  nxt_pw;
    logic [BW-1:0]   nxt_buf;
    logic [2:0]      nxt_cnt;
    logic [1:0]      nxt_err;

    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_en;
    logic            tmr_exp;

    logic            key_digit, key_enter, key_clear, key_set;
    logic            buf_full, match;
    logic [2:0]      err_inc;

    assign key_digit = key_valid && is_digit(key_code);
    assign key_enter = key_valid && (key_code == KEY_ENTER);
    assign key_clear = key_valid && (key_code == KEY_CLEAR);
    assign key_set   = key_valid && (key_code == KEY_SET);

    assign buf_full  = (digit_cnt == DIG_FULL);
    assign match     = buf_full && (entry_buf == password);
    // One bit wider so the increment can be compared against MAX_ERR without wrap.
    assign err_inc   = {1'b0, err_cnt} + 3'd1;

    lock_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_exp)
    );

    always_comb begin
        nxt_state = cur_state;
        nxt_buf   = entry_buf;
        nxt_cnt   = digit_cnt;
        nxt_err   = err_cnt;
        nxt_pw    = password;
        tmr_load  = 1'b0;
        tmr_val   = OPEN_VAL;
        tmr_en    = 1'b0;

        case (cur_state)
            ST_LOCKED: begin
                if (key_digit && !buf_full) begin
                    nxt_buf = {entry_buf[BW-5:0], key_code};
                    nxt_cnt = digit_cnt + 3'd1;
                end else if (key_clear) begin
                    nxt_buf = '0;
                    nxt_cnt = '0;
                end else if (key_enter) begin
                    nxt_state = ST_CHECK;
                end
            end

            ST_CHECK: begin
                nxt_buf = '0;
                nxt_cnt = '0;
                if (match) begin
                    nxt_err   = '0;
                    tmr_load  = 1'b1;
                    tmr_val   = OPEN_VAL;
                    nxt_state = ST_OPEN;
                end else if (err_inc >= 3'(MAX_ERR)) begin
                    nxt_err   = ERR_SAT;
                    tmr_load  = 1'b1;
                    tmr_val   = LOCK_VAL;
                    nxt_state = ST_ALARM;
                end else begin
                    nxt_err   = err_inc[1:0];
                    nxt_state = ST_LOCKED;
                end
            end

            ST_OPEN: begin
                tmr_en = 1'b1;
                // Expiry outranks any key arriving in the same cycle.
                if (tmr_exp || key_clear) begin
                    nxt_state = ST_LOCKED;
                end else if (key_set) begin
                    nxt_buf   = '0;
                    nxt_cnt   = '0;
                    nxt_state = ST_SET;
                end
            end

            ST_SET: begin
                // Timer is left frozen here; every exit reloads it.
                if (key_digit && !buf_full) begin
                    nxt_buf = {entry_buf[BW-5:0], key_code};
                    nxt_cnt = digit_cnt + 3'd1;
                end else if (key_clear) begin
                    nxt_buf   = '0;
                    nxt_cnt   = '0;
                    tmr_load  = 1'b1;
                    nxt_state = ST_OPEN;
                end else if (key_enter) begin
                    nxt_buf = '0;
                    nxt_cnt = '0;
                    if (buf_full) begin
                        nxt_pw    = entry_buf;
                        tmr_load  = 1'b1;
                        nxt_state = ST_OPEN;
                    end
                end
            end

            ST_ALARM: begin
                tmr_en = 1'b1;
                if (tmr_exp) begin
                    nxt_err   = '0;
                    nxt_state = ST_LOCKED;
                end
            end

            default: begin
                nxt_buf   = '0;
                nxt_cnt   = '0;
                nxt_state = ST_LOCKED;
            end
        endcase
    end

    // Flags are derived from the next state so they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_LOCKED;
            password  <= DEFAULT_PW;
            entry_buf <= '0;
            digit_cnt <= '0;
            err_cnt   <= '0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            password  <= nxt_pw;
            entry_buf <= nxt_buf;
            digit_cnt <= nxt_cnt;
            err_cnt   <= nxt_err;
            unlocked  <= (nxt_state == ST_OPEN) || (nxt_state == ST_SET);
            alarm     <= (nxt_state == ST_ALARM);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: open, lockout, short entry, password change, reset, expiry race.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: none.
module tb_lock_sequencer;

    localparam logic [3:0] K_ENTER = 4'hA;
    localparam logic [3:0] K_CLEAR = 4'hB;
    localparam logic [3:0] K_SET   = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        unlocked;
    logic        alarm;
    logic [1:0]  err_cnt;
    logic [2:0]  digit_cnt;
    logic [23:0] entry_buf;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    lock_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .err_cnt   (err_cnt),
        .digit_cnt (digit_cnt),
        .entry_buf (entry_buf),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle strobe; returns on the falling edge after the sampling edge.
    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic press_digits(input logic [23:0] pw);
        for (int i = 5; i >= 0; i--) press(pw[4*i +: 4]);
    endtask

    // Six digits + ENTER, then one more cycle so the CHECK result is visible.
    task automatic enter_pw(input logic [23:0] pw);
        press_digits(pw);
        press(K_ENTER);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},  32'(state),     32'd0);
        check({tag, "_unlock"}, 32'(unlocked),  32'd0);
        check({tag, "_alarm"},  32'(alarm),     32'd0);
        check({tag, "_err"},    32'(err_cnt),   32'd0);
        check({tag, "_dcnt"},   32'(digit_cnt), 32'd0);
        check({tag, "_buf"},    32'(entry_buf), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        wait_cyc(3);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // 1: correct code opens, then times out after exactly 500 cycles
        press_digits(24'h123456);
        check("t1_buf",  32'(entry_buf), 32'h123456);
        check("t1_dcnt", 32'(digit_cnt), 32'd6);
        press(K_ENTER);
        check("t1_check_state", 32'(state), 32'd1);
        @(negedge clk);
        check("t1_unlock",  32'(unlocked),  32'd1);
        check("t1_state",   32'(state),     32'd2);
        check("t1_err",     32'(err_cnt),   32'd0);
        check("t1_dcnt0",   32'(digit_cnt), 32'd0);
        wait_cyc(499);
        check("t1_open_last", 32'(unlocked), 32'd1);
        wait_cyc(1);
        check("t1_relock", 32'(unlocked), 32'd0);
        check("t1_locked", 32'(state),    32'd0);

        // 2: three failures -> alarm for 1000 cycles, keys ignored meanwhile
        enter_pw(24'h000000);
        check("t2_err1", 32'(err_cnt), 32'd1);
        check("t2_st1",  32'(state),   32'd0);
        enter_pw(24'h000000);
        check("t2_err2", 32'(err_cnt), 32'd2);
        enter_pw(24'h000000);
        check("t2_alarm",  32'(alarm),    32'd1);
        check("t2_err3",   32'(err_cnt),  32'd3);
        check("t2_st4",    32'(state),    32'd4);
        check("t2_unlock", 32'(unlocked), 32'd0);
        press(4'd1);
        press(K_ENTER);
        check("t2_ign_dcnt",  32'(digit_cnt), 32'd0);
        check("t2_ign_state", 32'(state),     32'd4);
        wait_cyc(995);
        check("t2_alarm_last", 32'(alarm), 32'd1);
        wait_cyc(1);
        check("t2_alarm_off", 32'(alarm),   32'd0);
        check("t2_err_clr",   32'(err_cnt), 32'd0);
        check("t2_locked",    32'(state),   32'd0);

        // 3: two failures, then the right code resets the count
        enter_pw(24'h111111);
        enter_pw(24'h999999);
        check("t3_err2", 32'(err_cnt), 32'd2);
        enter_pw(24'h123456);
        check("t3_err0",   32'(err_cnt),  32'd0);
        check("t3_unlock", 32'(unlocked), 32'd1);
        press(K_CLEAR);
        check("t3_clr_state",  32'(state),    32'd0);
        check("t3_clr_unlock", 32'(unlocked), 32'd0);

        // 4: short entry fails; seventh digit ignored
        press(4'd1); press(4'd2); press(4'd3);
        press(K_ENTER);
        @(negedge clk);
        check("t4_short_err", 32'(err_cnt),   32'd1);
        check("t4_short_st",  32'(state),     32'd0);
        check("t4_short_cnt", 32'(digit_cnt), 32'd0);
        for (int d = 1; d <= 7; d++) press(4'(d));
        check("t4_full_buf", 32'(entry_buf), 32'h123456);
        check("t4_full_cnt", 32'(digit_cnt), 32'd6);
        press(K_CLEAR);
        check("t4_clr_cnt", 32'(digit_cnt), 32'd0);
        check("t4_clr_buf", 32'(entry_buf), 32'd0);

        // 5: password change
        enter_pw(24'h123456);
        check("t5_open", 32'(unlocked), 32'd1);
        check("t5_err0", 32'(err_cnt),  32'd0);
        press(K_SET);
        check("t5_set_state",  32'(state),    32'd3);
        check("t5_set_unlock", 32'(unlocked), 32'd1);
        press(4'd1); press(4'd2);
        press(K_ENTER);
        check("t5_short_set_state", 32'(state),     32'd3);
        check("t5_short_set_cnt",   32'(digit_cnt), 32'd0);
        press_digits(24'h654321);
        press(K_ENTER);
        check("t5_set_done", 32'(state), 32'd2);
        press(K_CLEAR);
        check("t5_relock", 32'(state), 32'd0);
        enter_pw(24'h654321);
        check("t5_new_open", 32'(unlocked), 32'd1);
        press(K_CLEAR);
        enter_pw(24'h123456);
        check("t5_old_fail",   32'(unlocked), 32'd0);
        check("t5_old_failerr", 32'(err_cnt), 32'd1);

        // 6: reset mid-SET restores default password; expiry beats SET
        enter_pw(24'h654321);
        press(K_SET);
        press(4'd9); press(4'd9);
        check("t6_pre_dcnt", 32'(digit_cnt), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        enter_pw(24'h654321);
        check("t6_new_gone", 32'(unlocked), 32'd0);
        check("t6_new_err",  32'(err_cnt),  32'd1);
        enter_pw(24'h123456);
        check("t6_def_open", 32'(unlocked), 32'd1);
        wait_cyc(498);
        press(K_SET);
        check("t6_race_state",  32'(state),    32'd0);
        check("t6_race_unlock", 32'(unlocked), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
